ex_fwd_scoreboard: RTL and testbench
====================================

# ex_fwd_scoreboard

Parametrised EX-stage operand forwarding unit. It tracks the destination tags and results of the last DEPTH instructions that retired from EX, and resolves NUM_SRC source operands for the instruction now in EX. Sources come from the register file or from the youngest matching in-flight stage. When an operand depends on a load still in MEM, the unit raises a one-cycle load-use stall. It sits between the ID/EX register and the ALU, and replaces fixed 3-way bus forwarding muxes.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands resolved per cycle (≥1)
- DEPTH, 2, in-flight stages tracked after EX: entry 0 = MEM, entry 1 = WB, … (≥2)
- SEL_W, $clog2(DEPTH+1), per-source select width (derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pipe_en  in  1  global pipeline advance; entries shift only when high
- ex_valid  in  1  EX holds a real instruction
- ex_wen  in  1  EX instruction writes a register
- ex_is_load  in  1  EX instruction is a load (result not known until end of MEM)
- ex_rd  in  REG_AW  EX destination register
- ex_alu_result  in  DATA_W  EX ALU result, captured into entry 0
- mem_rdata  in  DATA_W  load data for entry 0, valid when entry 0 is a load
- ex_src_addr  in  NUM_SRC*REG_AW  source register addresses; source i is at [i*REG_AW +: REG_AW]
- ex_src_rf  in  NUM_SRC*DATA_W  register-file read values
- ex_src_fwd  out  NUM_SRC*DATA_W  resolved operands (combinational)
- fwd_sel  out  NUM_SRC*SEL_W  0 = RF, k = entry k-1
- fwd_stall  out  1  load-use hazard; upstream holds IF/ID/EX (combinational)

## Operation
- Entry fields: valid, wen, is_load, rd, data. Live = valid & wen & rd≠0.
- Per source i: scan entries 0..DEPTH-1, youngest first. The first live entry with rd == src_addr_i is selected; fwd_sel_i = k+1 and ex_src_fwd_i = entry data. No match or src_addr_i == 0: fwd_sel_i = 0 and ex_src_fwd_i = ex_src_rf_i.
- Hazard: fwd_stall = ex_valid & (some source i hits live entry 0 with is_load). Only entry 0 can stall. Entry ≥1 loads always carry data.
- While fwd_stall is high, that source's fwd_sel/fwd_src still reflect entry 0. The consumer ignores them because EX is held.
- Shift on rising edge when pipe_en:
  - entry 0 ← bubble (valid=0) if fwd_stall or !ex_valid; otherwise {1, ex_wen, ex_is_load, ex_rd, ex_alu_result}.
  - entry 1 ← entry 0, except data ← mem_rdata when entry 0 is valid & is_load.
  - entry k ← entry k-1 for k ≥ 2.
- pipe_en low: all entries hold, including the entry 0 load. fwd_stall persists until pipe_en shifts the load into entry 1.
- Duplicate rd across entries: youngest wins. A source matching ex_rd of the instruction itself is not forwarded (no self-forwarding).

## Timing
- Reset (rst_n low, async): every entry field = 0. Outputs are then fwd_stall=0, fwd_sel=0, ex_src_fwd=ex_src_rf.
- Reset mid-operation discards all in-flight tags immediately. The first edge after deassert behaves as from empty.
- Latency: an ALU result is forwardable the cycle after it leaves EX, from entry 0.
- Load result is forwardable two cycles after leaving EX, from entry 1. A dependent instruction directly behind a load therefore sees exactly 1 stall cycle, given pipe_en high.
- Entry data drops out of forwarding range DEPTH cycles (pipe_en edges) after leaving EX. The RF must hold it by then (write-before-read).

## Configuration
- EX_FWD_PERF_EN defined: adds outputs perf_stall_cnt (32) and perf_fwd_cnt (32). These are saturating counters, reset to 0.
  - perf_stall_cnt increments on each clk edge with fwd_stall & pipe_en.
  - perf_fwd_cnt increments once per edge with pipe_en & ex_valid & !fwd_stall & any fwd_sel_i≠0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package ex_fwd_pkg: entry struct typedef, SEL_RF = 0 constant, select-width function.
- Sub-module ex_fwd_match: one source, priority scan over DEPTH entries → {hit, sel, data, load_hazard}. Instantiated NUM_SRC times via generate.
- The top level holds the entry shift register, stall OR-reduction and optional counters.

## Test plan
- After reset, src_addr={3,4}, rf={0x11,0x22} → fwd={0x11,0x22}, sel={0,0}, stall=0.
- ALU writes r5=0xAAAA then next EX reads r5 → sel=1, fwd=0xAAAA. One cycle later (entry 1) → sel=2. After DEPTH+1 edges → sel=0, RF value.
- Load r7, next EX reads r7 → stall=1 for exactly one cycle and entry 0 becomes a bubble. mem_rdata=0x1234 at the shift; next cycle sel=2, fwd=0x1234, stall=0.
- r9 written by entry 1 (0x1) and entry 0 (0x2) → fwd=0x2, sel=1. Reading r0 with a live r0 write pending → sel=0, no stall.
- Load r7 in entry 0, pipe_en held low 3 cycles → stall stays 1 and entries frozen. rst_n pulsed mid-hold → stall=0 immediately and all sel=0.
- With EX_FWD_PERF_EN: the scenarios above → perf_stall_cnt equals the counted stall edges and perf_fwd_cnt equals the forwarded EX issues. Preloaded near 0xFFFFFFFF → saturates, no wrap.

Source files
------------

// File: rtl/ex_fwd_pkg.sv
// ----------------------------------------------------------------------------
// ex_fwd_pkg
//
// Purpose : shared types and helpers for the EX-stage forwarding scoreboard.
//           Holds the control part of an in-flight entry, the "select the
//           register file" code and the select-width helper. Register address
//           and data widths are instance parameters, so the full entry record
//           (control + rd + data) is built inside the module that owns it.
//
// Ports   : none (package).
// ----------------------------------------------------------------------------
package ex_fwd_pkg;

  // Select code meaning "take the register-file value"; entry k is k+1.
  localparam int SEL_RF = 0;

  // Control bits of one in-flight entry. An entry can forward only when it
  // is valid, writes a register, and that register is not r0.
  typedef struct packed {
    logic valid;
    logic wen;
    logic is_load;
  } entry_ctrl_t;

  // Width of a per-source select: RF plus one code per tracked entry.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ex_fwd_scoreboard_if.sv
// ----------------------------------------------------------------------------
// ex_fwd_scoreboard_if
//
// Purpose : bundles the EX-stage request, retire and forwarding result
//           signals of the forwarding scoreboard into one interface.
//
// Signals :
//   pipe_en        global pipeline advance
//   ex_valid       EX holds a real instruction
//   ex_wen         EX instruction writes a register
//   ex_is_load     EX instruction is a load
//   ex_rd          EX destination register
//   ex_alu_result  EX ALU result (captured into entry 0)
//   mem_rdata      load data for the load sitting in entry 0
//   ex_src_addr    NUM_SRC packed source register addresses
//   ex_src_rf      NUM_SRC packed register-file read values
//   ex_src_fwd     NUM_SRC packed resolved operands
//   fwd_sel        NUM_SRC packed selects (0 = RF, k = entry k-1)
//   fwd_stall      load-use hazard
//
// Modports: master = pipeline side (drives EX info, reads results),
//           slave  = scoreboard side.
// ----------------------------------------------------------------------------
interface ex_fwd_scoreboard_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
);

  localparam int SEL_W = ex_fwd_pkg::sel_width(DEPTH);

  logic                        pipe_en;
  logic                        ex_valid;
  logic                        ex_wen;
  logic                        ex_is_load;
  logic [REG_AW-1:0]           ex_rd;
  logic [DATA_W-1:0]           ex_alu_result;
  logic [DATA_W-1:0]           mem_rdata;
  logic [NUM_SRC*REG_AW-1:0]   ex_src_addr;
  logic [NUM_SRC*DATA_W-1:0]   ex_src_rf;
  logic [NUM_SRC*DATA_W-1:0]   ex_src_fwd;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        fwd_stall;

  modport master (
    output pipe_en, ex_valid, ex_wen, ex_is_load, ex_rd, ex_alu_result,
           mem_rdata, ex_src_addr, ex_src_rf,
    input  ex_src_fwd, fwd_sel, fwd_stall
  );

  modport slave (
    input  pipe_en, ex_valid, ex_wen, ex_is_load, ex_rd, ex_alu_result,
           mem_rdata, ex_src_addr, ex_src_rf,
    output ex_src_fwd, fwd_sel, fwd_stall
  );

endinterface

// File: rtl/ex_fwd_match.sv
// ----------------------------------------------------------------------------
// ex_fwd_match
//
// Purpose : resolves one source operand against the in-flight entries.
//           Entries are scanned youngest (entry 0) first; the first live
//           entry whose rd equals the source address wins. r0 never forwards.
//
// Ports   :
//   src_addr     in   source register address
//   src_rf       in   register-file value for this source
//   entry_live   in   per-entry live flag (valid & wen & rd != 0)
//   entry0_load  in   entry 0 holds a load whose data is not yet known
//   entry_rd     in   packed rd of every entry, entry k at [k*REG_AW +: REG_AW]
//   entry_data   in   packed data of every entry, entry k at [k*DATA_W +: DATA_W]
//   hit          out  some live entry matched
//   sel          out  0 = RF, k+1 = entry k
//   data         out  resolved operand
//   load_hazard  out  the winning entry is the load still in MEM
// ----------------------------------------------------------------------------
module ex_fwd_match
  import ex_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic [REG_AW-1:0]                          src_addr,
  input  logic [DATA_W-1:0]                          src_rf,
  input  logic [DEPTH-1:0]                           entry_live,
  input  logic                                       entry0_load,
  input  logic [DEPTH*REG_AW-1:0]                    entry_rd,
  input  logic [DEPTH*DATA_W-1:0]                    entry_data,
  output logic                                       hit,
  output logic [ex_fwd_pkg::sel_width(DEPTH)-1:0]    sel,
  output logic [DATA_W-1:0]                          data,
  output logic                                       load_hazard
);

  localparam int SEL_W = sel_width(DEPTH);

  // Priority scan. Walking from the oldest entry towards entry 0 and letting
  // each later match overwrite the earlier one leaves the youngest match in
  // place, which is the required "youngest producer wins" rule.
  always_comb begin
    hit         = 1'b0;
    sel         = SEL_W'(SEL_RF);
    data        = src_rf;
    load_hazard = 1'b0;
    if (src_addr != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (entry_live[k] && (entry_rd[k*REG_AW +: REG_AW] == src_addr)) begin
          hit         = 1'b1;
          sel         = SEL_W'(k + 1);
          data        = entry_data[k*DATA_W +: DATA_W];
          load_hazard = (k == 0) && entry0_load;
        end
      end
    end
  end

endmodule

// File: rtl/ex_fwd_scoreboard.sv
// ----------------------------------------------------------------------------
// ex_fwd_scoreboard
//
// Purpose : EX-stage operand forwarding unit. Remembers destination tags and
//           results of the last DEPTH instructions that left EX (entry 0 =
//           MEM, entry 1 = WB, ...) and resolves NUM_SRC source operands of
//           the instruction now in EX. A source that depends on a load still
//           in MEM raises fwd_stall for one cycle.
//
// Ports   :
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   bus             slave modport of ex_fwd_scoreboard_if (EX info in,
//                   resolved operands / selects / stall out)
//   perf_stall_cnt  out  32-bit saturating count of stall edges    (*)
//   perf_fwd_cnt    out  32-bit saturating count of forwarded issues (*)
//
// (*) only present when the macro EX_FWD_PERF_EN is defined; without it the
//     unit is otherwise identical.
// ----------------------------------------------------------------------------
module ex_fwd_scoreboard
  import ex_fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ex_fwd_scoreboard_if.slave   bus
`ifdef EX_FWD_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_fwd_cnt
`endif
);

  localparam int SEL_W = sel_width(DEPTH);

  typedef struct packed {
    entry_ctrl_t       ctrl;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                      entries [DEPTH];
  entry_t                      next_entry0;
  entry_t                      aged_entry0;

  logic [DEPTH-1:0]            entry_live;
  logic [DEPTH*REG_AW-1:0]     entry_rd;
  logic [DEPTH*DATA_W-1:0]     entry_data;

  logic [NUM_SRC-1:0]          src_hit;
  logic [NUM_SRC-1:0]          src_hazard;
  logic [NUM_SRC*SEL_W-1:0]    src_sel;
  logic [NUM_SRC*DATA_W-1:0]   src_fwd;
  logic                        fwd_stall;

  // Flatten the entries into the packed views the match units scan. An
  // entry is live only if it will actually write a non-zero register.
  always_comb begin
    entry_live = '0;
    entry_rd   = '0;
    entry_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entry_live[k]                  = entries[k].ctrl.valid & entries[k].ctrl.wen &
                                       (entries[k].rd != '0);
      entry_rd[k*REG_AW +: REG_AW]   = entries[k].rd;
      entry_data[k*DATA_W +: DATA_W] = entries[k].data;
    end
  end

  // One priority match unit per source operand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ex_fwd_match #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH)
    ) u_match (
      .src_addr    (bus.ex_src_addr[i*REG_AW +: REG_AW]),
      .src_rf      (bus.ex_src_rf[i*DATA_W +: DATA_W]),
      .entry_live  (entry_live),
      .entry0_load (entries[0].ctrl.is_load),
      .entry_rd    (entry_rd),
      .entry_data  (entry_data),
      .hit         (src_hit[i]),
      .sel         (src_sel[i*SEL_W +: SEL_W]),
      .data        (src_fwd[i*DATA_W +: DATA_W]),
      .load_hazard (src_hazard[i])
    );
  end

  // A hazard only counts for a source that really picked entry 0, and only
  // when EX holds a real instruction.
  assign fwd_stall      = bus.ex_valid & (|(src_hit & src_hazard));
  assign bus.fwd_stall  = fwd_stall;
  assign bus.fwd_sel    = src_sel;
  assign bus.ex_src_fwd = src_fwd;

  // Next contents of entry 0: the EX instruction, or a bubble when EX is
  // empty or being held by a load-use stall (the held instruction will be
  // captured once the stall clears).
  always_comb begin
    next_entry0 = '0;
    if (bus.ex_valid && !fwd_stall) begin
      next_entry0.ctrl.valid   = 1'b1;
      next_entry0.ctrl.wen     = bus.ex_wen;
      next_entry0.ctrl.is_load = bus.ex_is_load;
      next_entry0.rd           = bus.ex_rd;
      next_entry0.data         = bus.ex_alu_result;
    end
  end

  // Entry 0 as it moves into entry 1: a load picks up its memory data here,
  // so every entry from 1 onward always carries the final result.
  always_comb begin
    aged_entry0 = entries[0];
    if (entries[0].ctrl.valid && entries[0].ctrl.is_load) begin
      aged_entry0.data = bus.mem_rdata;
    end
  end

  // The entry shift register. Everything holds while pipe_en is low, which
  // keeps a pending load in entry 0 and therefore keeps the stall asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries[k] <= '0;
      end
    end else if (bus.pipe_en) begin
      entries[0] <= next_entry0;
      entries[1] <= aged_entry0;
      for (int k = 2; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

`ifdef EX_FWD_PERF_EN
  logic any_fwd;

  assign any_fwd = |src_hit;

  // Saturating event counters: stall edges, and EX issues that took at
  // least one operand from the forwarding network.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (bus.pipe_en && fwd_stall && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (bus.pipe_en && bus.ex_valid && !fwd_stall && any_fwd &&
          (perf_fwd_cnt != '1)) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_fwd_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_ex_fwd_scoreboard
//
// Bench for ex_fwd_scoreboard. A driver applies one EX cycle at a time and
// pushes the expected outputs, computed from a history list of instructions
// that left EX, into a queue; a monitor pops and compares at every falling
// edge. Directed scenarios come first, then randomized traffic.
// Optional counters are checked when EX_FWD_PERF_EN is defined.
// ----------------------------------------------------------------------------
module tb_ex_fwd_scoreboard;
  import ex_fwd_pkg::*;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int SEL_W   = sel_width(DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ex_fwd_scoreboard_if #(
    .DATA_W (DATA_W), .REG_AW (REG_AW), .NUM_SRC (NUM_SRC), .DEPTH (DEPTH)
  ) bus ();

`ifdef EX_FWD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
`endif

  ex_fwd_scoreboard #(
    .DATA_W (DATA_W), .REG_AW (REG_AW), .NUM_SRC (NUM_SRC), .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef EX_FWD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  typedef struct {
    logic [NUM_SRC*SEL_W-1:0]  sel;
    logic [NUM_SRC*DATA_W-1:0] fwd;
    logic                      stall;
  } exp_t;

  // One instruction that left EX (or a bubble). Index 0 of the history is
  // the most recent one.
  typedef struct {
    bit                valid;
    bit                wen;
    bit                is_load;
    int                rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
  } instr_t;

  exp_t        exp_q [$];
  instr_t      hist  [$];
  int          check_count = 0;
  int          pass_count  = 0;
  bit          last_stall  = 1'b0;
  logic [31:0] model_stall_cnt = '0;
  logic [31:0] model_fwd_cnt   = '0;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Youngest producer of addr among the last DEPTH instructions. A load's
  // memory data is only known once it is one step older than MEM.
  function automatic void model_resolve(input int addr, output int sel,
                                        output logic [DATA_W-1:0] val, output bit hz);
    sel = 0;
    val = '0;
    hz  = 1'b0;
    if (addr == 0) return;
    for (int k = 0; k < hist.size() && k < DEPTH; k++) begin
      if (hist[k].valid && hist[k].wen && hist[k].rd == addr) begin
        sel = k + 1;
        val = (hist[k].is_load && k >= 1) ? hist[k].mem : hist[k].alu;
        hz  = (k == 0) && hist[k].is_load;
        return;
      end
    end
  endfunction

  function automatic logic [NUM_SRC*REG_AW-1:0] src2(input int a0, input int a1);
    return {REG_AW'(a1), REG_AW'(a0)};
  endfunction

  function automatic logic [NUM_SRC*DATA_W-1:0] rf2(input logic [DATA_W-1:0] v0,
                                                    input logic [DATA_W-1:0] v1);
    return {v1, v0};
  endfunction

  // Drive one cycle of EX inputs, queue what the outputs must be, then let
  // the edge happen and age the history the way the pipeline would.
  task automatic applyStimulus(input bit pe, input bit ev, input bit wen, input bit ld,
                               input int rd, input logic [DATA_W-1:0] alu,
                               input logic [DATA_W-1:0] mem,
                               input logic [NUM_SRC*REG_AW-1:0] src,
                               input logic [NUM_SRC*DATA_W-1:0] rf);
    exp_t              e;
    int                s;
    logic [DATA_W-1:0] v;
    bit                hz;
    bit                hz_any;
    bit                any_fwd;
    instr_t            n;
    instr_t            t;
    bus.pipe_en       = pe;
    bus.ex_valid      = ev;
    bus.ex_wen        = wen;
    bus.ex_is_load    = ld;
    bus.ex_rd         = REG_AW'(rd);
    bus.ex_alu_result = alu;
    bus.mem_rdata     = mem;
    bus.ex_src_addr   = src;
    bus.ex_src_rf     = rf;
    e.sel   = '0;
    e.fwd   = '0;
    hz_any  = 1'b0;
    any_fwd = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      model_resolve(int'(src[i*REG_AW +: REG_AW]), s, v, hz);
      e.sel[i*SEL_W +: SEL_W]   = SEL_W'(s);
      e.fwd[i*DATA_W +: DATA_W] = (s == 0) ? rf[i*DATA_W +: DATA_W] : v;
      hz_any  = hz_any | hz;
      any_fwd = any_fwd | (s != 0);
    end
    e.stall = ev && hz_any;
    exp_q.push_back(e);
    last_stall = e.stall;
    @(posedge clk);
    if (rst_n && pe) begin
      if (e.stall && model_stall_cnt != 32'hFFFF_FFFF) model_stall_cnt++;
      if (ev && !e.stall && any_fwd && model_fwd_cnt != 32'hFFFF_FFFF) model_fwd_cnt++;
      if (hist.size() > 0 && hist[0].valid && hist[0].is_load) begin
        t       = hist[0];
        t.mem   = mem;
        hist[0] = t;
      end
      n.valid   = ev && !e.stall;
      n.wen     = wen;
      n.is_load = ld;
      n.rd      = rd;
      n.alu     = alu;
      n.mem     = '0;
      hist.push_front(n);
      while (hist.size() > DEPTH) void'(hist.pop_back());
    end
    #1;
  endtask

  // Monitor: the outputs are combinational, so one expectation is presented
  // per cycle and checked mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("fwd_stall", DATA_W'(bus.fwd_stall), DATA_W'(e.stall));
        for (int i = 0; i < NUM_SRC; i++) begin
          checkOutput($sformatf("fwd_sel[%0d]", i),
                      DATA_W'(bus.fwd_sel[i*SEL_W +: SEL_W]), DATA_W'(e.sel[i*SEL_W +: SEL_W]));
          checkOutput($sformatf("ex_src_fwd[%0d]", i),
                      bus.ex_src_fwd[i*DATA_W +: DATA_W], e.fwd[i*DATA_W +: DATA_W]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : driver
    bit                        r_ev, r_wen, r_ld;
    int                        r_rd;
    logic [DATA_W-1:0]         r_alu;
    logic [NUM_SRC*REG_AW-1:0] r_src;
    logic [NUM_SRC*DATA_W-1:0] r_rf;

    bus.pipe_en = 1'b0; bus.ex_valid = 1'b0; bus.ex_wen = 1'b0; bus.ex_is_load = 1'b0;
    bus.ex_rd = '0; bus.ex_alu_result = '0; bus.mem_rdata = '0;
    bus.ex_src_addr = '0; bus.ex_src_rf = '0;
    $display("[TB] starting");

    repeat (2) @(posedge clk);
    #1;
    // Held in reset: outputs pass the RF values through.
    applyStimulus(1, 1, 1, 1, 7, 32'h5, 32'h6, src2(3, 4), rf2(32'h11, 32'h22));
    rst_n = 1'b1;

    // Empty after reset.
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0, src2(3, 4), rf2(32'h11, 32'h22));

    // ALU r5 result forwarded from entry 0, then entry 1, then out of range.
    applyStimulus(1, 1, 1, 0, 5, 32'hAAAA, 32'h0, src2(1, 2), rf2(32'h1, 32'h2));
    applyStimulus(1, 1, 1, 0, 6, 32'h0BBB, 32'h0, src2(5, 0), rf2(32'h55, 32'h66));
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 32'h0, src2(0, 5), rf2(32'h77, 32'h88));
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 32'h0, src2(5, 6), rf2(32'h99, 32'hAA));

    // Load r7 followed by a dependent: one stall, data taken at the shift.
    applyStimulus(1, 1, 1, 1, 7, 32'hDEAD, 32'h0, src2(1, 2), rf2(32'h1, 32'h2));
    applyStimulus(1, 1, 1, 0, 8, 32'h77, 32'h1234, src2(7, 3), rf2(32'h3, 32'h4));
    applyStimulus(1, 1, 1, 0, 8, 32'h77, 32'h9999, src2(7, 3), rf2(32'h3, 32'h4));

    // Two producers of r9: youngest wins; r0 writes never forward.
    applyStimulus(1, 1, 1, 0, 9, 32'h1, 32'h0, src2(0, 0), rf2(32'h0, 32'h0));
    applyStimulus(1, 1, 1, 0, 9, 32'h2, 32'h0, src2(0, 0), rf2(32'h0, 32'h0));
    applyStimulus(1, 1, 1, 0, 0, 32'h3, 32'h0, src2(9, 0), rf2(32'h5, 32'h6));
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 32'h0, src2(0, 9), rf2(32'h7, 32'h8));

    // Load r7 with the pipeline frozen: stall persists, then reset clears it.
    applyStimulus(1, 1, 1, 1, 7, 32'hBEEF, 32'h0, src2(1, 2), rf2(32'h1, 32'h2));
    repeat (3) applyStimulus(0, 1, 1, 0, 8, 32'h1, 32'h2, src2(7, 7), rf2(32'hA, 32'hB));
    rst_n = 1'b0;
    hist.delete();
    model_stall_cnt = '0;
    model_fwd_cnt   = '0;
    applyStimulus(0, 1, 1, 0, 8, 32'h1, 32'h2, src2(7, 7), rf2(32'hA, 32'hB));
    rst_n = 1'b1;
    applyStimulus(1, 1, 1, 0, 8, 32'h1, 32'h2, src2(7, 7), rf2(32'hA, 32'hB));

    // Random traffic; a stalled EX instruction is held until it issues.
    r_ev = 1'b0; r_wen = 1'b0; r_ld = 1'b0; r_rd = 0; r_alu = '0; r_src = '0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        r_ev  = ($urandom_range(0, 9) != 0);
        r_wen = ($urandom_range(0, 4) != 0);
        r_ld  = ($urandom_range(0, 3) == 0);
        r_rd  = int'($urandom_range(0, 7));
        r_alu = $urandom;
        for (int i = 0; i < NUM_SRC; i++) r_src[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      end
      for (int i = 0; i < NUM_SRC; i++) r_rf[i*DATA_W +: DATA_W] = $urandom;
      applyStimulus(($urandom_range(0, 7) != 0), r_ev, r_wen, r_ld, r_rd, r_alu,
                    $urandom, r_src, r_rf);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check_count++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

`ifdef EX_FWD_PERF_EN
    checkOutput("perf_stall_cnt", perf_stall_cnt, model_stall_cnt);
    checkOutput("perf_fwd_cnt", perf_fwd_cnt, model_fwd_cnt);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
